// File: rtl/ps_accumulator.sv
// Dot-product accumulator: sums signed product beats with saturation, adds a bias,
// then requantizes (shift, optional ReLU, clamp) and holds the result until it is taken.
//
// state | meaning
// ------+-----------------------------------------------------------
// ACC   | accepting product beats into acc
// BIAS  | one cycle: add the sampled bias to acc
// QUANT | one cycle: shift/ReLU/clamp acc into out_data
// HOLD  | result valid; wait for out_ready, then clear for next group
module ps_accumulator #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 8,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    input  logic [15:0]      bias,
    input  logic             relu_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [ACC_W-1:0] out_acc,
    output logic             ovf,
    output logic [7:0]       term_cnt
);

    typedef enum logic [1:0] {ACC, BIAS, QUANT, HOLD} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN   = ~Q_MAX;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [15:0]             bias_q;
    logic                    relu_q;
    logic                    accept;
    logic [15:0]             addend;
    logic [ACC_W:0]          sum;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] sum_sat;
    logic signed [ACC_W-1:0] q_shift;
    logic signed [ACC_W-1:0] q_relu;
    logic [OUT_W-1:0]        q_sat;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign accept    = in_valid && in_ready;

    // One shared saturating adder: beats in ACC, the sampled bias in BIAS.
    assign addend  = (state == BIAS) ? bias_q : in_prod;
    assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){addend[15]}}, addend};
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    assign sum_sat = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    assign q_shift = acc >>> SHIFT;
    assign q_relu  = (relu_q && q_shift[ACC_W-1]) ? '0 : q_shift;

    always_comb begin
        q_sat = q_relu[OUT_W-1:0];
        if (q_relu > Q_MAX)
            q_sat = Q_MAX[OUT_W-1:0];
        else if (q_relu < Q_MIN)
            q_sat = Q_MIN[OUT_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && in_last) state_nxt = BIAS;
            BIAS:    state_nxt = QUANT;
            QUANT:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACC;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            ovf      <= 1'b0;
            term_cnt <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= sum_sat;
                        ovf <= ovf | sum_ovf;
                        if (term_cnt != 8'hFF)
                            term_cnt <= term_cnt + 8'd1;
                        if (in_last) begin
                            bias_q <= bias;
                            relu_q <= relu_en;
                        end
                    end
                end
                BIAS: begin
                    acc <= sum_sat;
                    ovf <= ovf | sum_ovf;
                end
                QUANT: out_data <= q_sat;
                HOLD: begin
                    if (out_ready) begin
                        acc      <= '0;
                        ovf      <= 1'b0;
                        term_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_accumulator.sv
// Bench for ps_accumulator: a 24-bit and a 17-bit instance share all stimulus and are
// compared against an integer reference model of the accumulate/bias/requantize rules.
module tb_ps_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        relu_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_prod = '0;
    logic [15:0] bias = '0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [7:0]  out_data_a, term_cnt_a;
    logic [23:0] out_acc_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [7:0]  out_data_b, term_cnt_b;
    logic [16:0] out_acc_b;

    int tests = 0;
    int fails = 0;
    logic signed [15:0] gq[$];

    always #5 clk = ~clk;

    ps_accumulator #(.ACC_W(24), .SHIFT(8), .OUT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_prod(in_prod), .in_last(in_last), .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_acc(out_acc_a), .ovf(ovf_a), .term_cnt(term_cnt_a)
    );

    ps_accumulator #(.ACC_W(17), .SHIFT(8), .OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_prod(in_prod), .in_last(in_last), .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_acc(out_acc_b), .ovf(ovf_b), .term_cnt(term_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] msk(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain integer arithmetic with clamping after every add.
    task automatic model(input int w, input logic [15:0] b, input logic r,
                         output longint acc, output bit ov, output longint q);
        longint mx, mn;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        acc = 0;
        ov  = 0;
        for (int i = 0; i < gq.size(); i++) begin
            acc = acc + longint'(gq[i]);
            if (acc > mx) begin acc = mx; ov = 1; end
            else if (acc < mn) begin acc = mn; ov = 1; end
        end
        acc = acc + longint'($signed(b));
        if (acc > mx) begin acc = mx; ov = 1; end
        else if (acc < mn) begin acc = mn; ov = 1; end
        q = acc >>> 8;
        if (r && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
    endtask

    task automatic scramble();
        in_last = 1'($urandom);
        bias    = 16'($urandom);
        relu_en = 1'($urandom);
        in_prod = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic l, input logic [15:0] b, input logic r);
        int k = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        bias     = b;
        relu_en  = r;
        while (!in_ready_a && k < 50) begin
            tick();
            k++;
        end
        check("beat_ready", in_ready_a, 1);
        tick();
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic run_group(input logic [15:0] b, input logic r, input int stall);
        longint ea, eb, qa, qb;
        bit oa, ob;
        int n;
        n = gq.size();
        model(24, b, r, ea, oa, qa);
        model(17, b, r, eb, ob, qb);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == n - 1) beat(gq[i], 1'b1, b, r);
            else            beat(gq[i], 1'b0, 16'($urandom), 1'($urandom));
        end
        check("lat0_valid", out_valid_a, 0);
        check("lat0_ready", in_ready_a, 0);
        tick();
        check("lat1_valid", out_valid_a, 0);
        tick();
        check("lat2_valid_a", out_valid_a, 1);
        check("lat2_valid_b", out_valid_b, 1);
        check("data_a", out_data_a, msk(qa, 8));
        check("acc_a", out_acc_a, msk(ea, 24));
        check("ovf_a", ovf_a, oa);
        check("term_a", term_cnt_a, (n > 255) ? 255 : n);
        check("data_b", out_data_b, msk(qb, 8));
        check("acc_b", out_acc_b, msk(eb, 17));
        check("ovf_b", ovf_b, ob);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            scramble();
            tick();
            check("stall_ready", in_ready_a, 0);
            check("stall_valid", out_valid_a, 1);
            check("stall_data", out_data_a, msk(qa, 8));
            check("stall_acc", out_acc_a, msk(ea, 24));
            check("stall_ovf", ovf_a, oa);
            check("stall_term", term_cnt_a, (n > 255) ? 255 : n);
        end
        in_valid  = 1'b1;
        in_prod   = 16'h1234;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hs_ready", in_ready_a, 1);
        check("hs_valid", out_valid_a, 0);
        check("hs_acc_a", out_acc_a, 0);
        check("hs_acc_b", out_acc_b, 0);
        check("hs_ovf_b", ovf_b, 0);
        check("hs_term", term_cnt_a, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_acc"}, out_acc_a, 0);
        check({tag, "_data"}, out_data_a, 0);
        check({tag, "_valid"}, out_valid_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
        check({tag, "_term"}, term_cnt_a, 0);
    endtask

    initial begin
        #12;
        reset_checks("rst");
        #1 rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready_a, 1);

        gq = {16'sh0100, 16'sh0200, 16'sh0300};
        run_group(16'h0000, 1'b0, 0);
        gq = {16'shFF00};
        run_group(16'hFE00, 1'b1, 0);
        run_group(16'hFE00, 1'b0, 1);
        gq = {16'sh7FFF, 16'sh7FFF};
        run_group(16'h0000, 1'b0, 0);
        gq = {16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        run_group(16'h0000, 1'b0, 5);
        gq = {16'sh0010};
        run_group(16'h0000, 1'b0, 0);

        // Reset mid-group must drop the partial sum.
        beat(16'h0100, 1'b0, 16'h0000, 1'b0);
        beat(16'h0200, 1'b0, 16'h0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready", in_ready_a, 1);
        gq = {16'sh0100};
        run_group(16'h0000, 1'b0, 0);

        // Long group: saturates the 24-bit accumulator and term_cnt.
        gq = {};
        for (int i = 0; i < 300; i++) gq.push_back(16'sh7FFF);
        run_group(16'h7FFF, 1'b0, 0);

        for (int g = 0; g < 25; g++) begin
            int n;
            n  = $urandom_range(1, 10);
            gq = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) gq.push_back($urandom_range(0, 1) ? 16'sh7FFF : 16'sh8000);
                else gq.push_back(16'($urandom));
            end
            run_group(16'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps_accumulator.md
PS_ACCUMULATOR -- requirements
Module: ps_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits; legal range 17..32.
REQ-002 Parameter SHIFT, default 8: arithmetic right shift applied at requantization; legal range 0..ACC_W-1.
REQ-003 Parameter OUT_W, default 8: width of the requantized output; legal range 2..16.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  product beat present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_prod  input  16  signed two's-complement product from the multiplier stage.
REQ-010 in_last  input  1  beat is the final term of the current dot product.
REQ-011 bias  input  16  signed bias; sampled only on an accepted beat with in_last=1.
REQ-012 relu_en  input  1  ReLU enable; sampled only on an accepted beat with in_last=1.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_data  output  OUT_W  signed requantized, saturated result.
REQ-016 out_acc  output  ACC_W  raw accumulator value including bias.
REQ-017 ovf  output  1  sticky flag: accumulator or bias add saturated in the current group.
REQ-018 term_cnt  output  8  number of beats accepted in the current group, saturating at 255.

Function
REQ-019 The FSM SHALL have four states: ACC, BIAS, QUANT, HOLD.
REQ-020 in_ready SHALL be 1 exactly when the state is ACC.
REQ-021 A beat is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-022 On acceptance, acc SHALL be updated to sat(acc + sign-extended in_prod) and term_cnt incremented, saturating at 255.
REQ-023 Transition ACC->BIAS on an accepted beat with in_last=1; otherwise stay in ACC.
REQ-024 BIAS SHALL last one cycle: acc <= sat(acc + sign-extended bias), then go to QUANT.
REQ-025 QUANT SHALL last one cycle and register out_data as follows, then go to HOLD: q = acc >>> SHIFT; if the sampled relu_en=1 and q<0, q=0; out_data = clamp(q, -2^(OUT_W-1), 2^(OUT_W-1)-1).
REQ-026 out_valid SHALL be 1 exactly in HOLD; it is first visible after the second rising edge following the edge that accepted the in_last beat (latency 2 cycles).
REQ-027 In HOLD with out_ready=0, out_data, out_acc, ovf and term_cnt SHALL stay stable and no beats are accepted.
REQ-028 In HOLD, a rising edge with out_ready=1 SHALL go to ACC and clear acc, ovf and term_cnt to 0.
REQ-029 in_ready SHALL rise in the cycle after the output handshake; there is no same-cycle bypass.
REQ-030 sat() SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow and set ovf=1; ovf holds until cleared per REQ-028 or by reset.
REQ-031 A group of a single beat with in_last=1 is legal and follows the same path.
REQ-032 in_last, bias and relu_en SHALL be ignored on cycles with no acceptance.
REQ-033 out_acc SHALL show acc continuously.

Reset
REQ-034 While rst_n=0, state SHALL be ACC, and acc, out_data, out_valid, ovf, term_cnt and sampled relu_en SHALL be 0.
REQ-035 in_ready SHALL read 1 from the first cycle after reset release.
REQ-036 Reset asserted mid-group or in HOLD SHALL discard all partial state; the next group starts from acc=0.

Verification (ACC_W=24, SHIFT=8, OUT_W=8 unless stated)
REQ-037 Beats 0x0100, 0x0200, 0x0300(last), bias 0, relu_en 0 -> out_acc=0x000600, out_data=6, term_cnt=3, out_valid 2 cycles after the last beat.
REQ-038 Beat 0xFF00(last), bias 0xFE00, relu_en 1 -> out_acc=0xFFFD00, out_data=0; with relu_en 0 -> out_data=0xFD.
REQ-039 Beats 0x7FFF, 0x7FFF(last), bias 0 -> out_acc=0x00FFFE, out_data=0x7F (saturated), ovf=0.
REQ-040 ACC_W=17, three beats 0x7FFF (third last) -> out_acc=0x0FFFF, ovf=1; next group after handshake has ovf=0.
REQ-041 HOLD with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> next group result excludes the stalled beats' predecessors.
REQ-042 Two beats accepted, then rst_n pulsed low -> all outputs 0; beat 0x0100(last) -> out_data=1, term_cnt=1.
